glyph_prefetch: RTL

Sequencer and double buffer for the character ROM. On every vertical-blank entry it fetches all 16 rows of the currently selected glyph from the ROM into a back bank, then swaps banks while still in blanking. The display controller always reads a stable front bank, so a keyboard digit change never tears mid-frame. It sits between the input decoder and display controller on one side and the ROM controller on the other, and it is the only source of the ROM read enable.

---
 rtl/glyph_prefetch_pkg.sv | 14 +
 rtl/glyph_prefetch_bank.sv | 41 ++++
 rtl/glyph_prefetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/glyph_prefetch_pkg.sv
// Shared glyph constants and prefetch FSM encodings.
// Also used by the display and ROM controllers.
package glyph_prefetch_pkg;

  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_AW   = 4;
  localparam int GLYPH_DW   = 8;
  localparam int NUM_W      = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/glyph_prefetch_bank.sv
// Two-bank glyph register file.
// Writes go to the back bank; the registered read returns the front bank.
module glyph_bank
  import glyph_prefetch_pkg::*;
#(
  parameter int ROWS  = GLYPH_ROWS,
  parameter int WIDTH = GLYPH_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [GLYPH_AW-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                front_sel,
  input  logic [GLYPH_AW-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [1:0][ROWS-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]                rd_q, rd_d;

  // Read uses the pre-edge front_sel, so a swap shows up one cycle later.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[~front_sel][waddr] = wdata;
    rd_d = mem_q[front_sel][raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/glyph_prefetch.sv
// Vblank-triggered glyph prefetch into a double-buffered bank.
// Fetches 16 rows from the ROM, then swaps banks inside blanking.
module glyph_prefetch
  import glyph_prefetch_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int ROWS    = GLYPH_ROWS,
  parameter int WIDTH   = GLYPH_DW
) (
  input  logic                pixelClk,
  input  logic                reset,
  input  logic                vblank,
  input  logic [NUM_W-1:0]    userNum,
  input  logic [WIDTH-1:0]    romByte,
  output logic                readEn,
  output logic [NUM_W-1:0]    romNum,
  output logic [GLYPH_AW-1:0] romAddr,
  input  logic [GLYPH_AW-1:0] rdAddr,
  output logic [WIDTH-1:0]    rdByte,
  output logic                bufValid,
  output logic                bankSwap,
  output logic                fetchAbort
);

  localparam int CW = $clog2(ROWS + 1);

  logic [1:0]          state_q, state_d;
  logic                vblank_q, vblank_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [GLYPH_AW-1:0] addr_q, addr_d;
  logic [CW-1:0]       cap_q, cap_d;
  logic                front_q, front_d;
  logic                valid_q, valid_d;
  logic [ROM_LAT-1:0]  vp_q, vp_d;
  logic [ROM_LAT-1:0][GLYPH_AW-1:0] ap_q, ap_d;

  logic edge_e, busy, abort, issue, cap_we, swap;

  always_comb begin
    edge_e = vblank & ~vblank_q;
    busy   = (state_q != IDLE);
    abort  = busy & ~vblank;
    issue  = (state_q == FETCH) & vblank;
    cap_we = vp_q[ROM_LAT-1];
    swap   = (state_q == DRAIN) & vblank
           & (cap_q == CW'(ROWS));

    state_d  = state_q;
    vblank_d = vblank;
    num_d    = num_q;
    addr_d   = addr_q;
    cap_d    = cap_q;
    front_d  = front_q;
    valid_d  = valid_q;

    // Delayed valid/address pipe matching ROM latency.
    vp_d    = vp_q;
    ap_d    = ap_q;
    vp_d[0] = issue;
    ap_d[0] = addr_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      vp_d[i] = vp_q[i-1];
      ap_d[i] = ap_q[i-1];
    end

    if (cap_we) cap_d = cap_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (edge_e) begin
          num_d   = userNum;
          addr_d  = '0;
          cap_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (vblank) begin
          if (addr_q == GLYPH_AW'(ROWS - 1))
            state_d = DRAIN;
          else
            addr_d = addr_q + GLYPH_AW'(1);
        end
      end
      DRAIN: begin
        if (swap) begin
          front_d = ~front_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      vp_d    = '0;
    end
  end

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vblank_q <= 1'b0;
      num_q    <= '0;
      addr_q   <= '0;
      cap_q    <= '0;
      front_q  <= 1'b0;
      valid_q  <= 1'b0;
      vp_q     <= '0;
      ap_q     <= '0;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank_d;
      num_q    <= num_d;
      addr_q   <= addr_d;
      cap_q    <= cap_d;
      front_q  <= front_d;
      valid_q  <= valid_d;
      vp_q     <= vp_d;
      ap_q     <= ap_d;
    end
  end

  glyph_bank #(
    .ROWS  (ROWS),
    .WIDTH (WIDTH)
  ) u_bank (
    .clk       (pixelClk),
    .rst       (reset),
    .we        (cap_we),
    .waddr     (ap_q[ROM_LAT-1]),
    .wdata     (romByte),
    .front_sel (front_q),
    .raddr     (rdAddr),
    .rdata     (rdByte)
  );

  assign readEn     = issue;
  assign romNum     = num_q;
  assign romAddr    = addr_q;
  assign bufValid   = valid_q;
  assign bankSwap   = swap;
  assign fetchAbort = abort;

endmodule
